// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- program-counter and fetch-enable generator for the IF stage.
//
// Produces the instruction-memory fetch address (pc) and chip-enable (ce).
// Besides sequential increment it handles a pipeline stall vector, an
// instruction-memory wait handshake, branch redirects (captured while the
// stage is held and replayed once it is released), exception/flush
// redirects and a misaligned-PC flag.
//
// Ports:
//   clk           in   clock, all state changes on the rising edge
//   rst           in   synchronous active-high reset
//   stall         in   pipeline stall vector; only stall[STALL_BIT] is used
//   imem_ready    in   instruction memory accepted the current fetch (0 = wait)
//   br_valid      in   branch/jump taken this cycle
//   br_target     in   branch target address
//   flush         in   exception/eret redirect, highest priority
//   flush_pc      in   flush redirect target
//   pc            out  current fetch address (registered)
//   ce            out  instruction-memory enable (registered)
//   pc_misaligned out  pc has nonzero low ALIGN_BITS (registered with pc)
//   br_pending    out  a branch redirect is latched, waiting for hold to drop
// ---------------------------------------------------------------------------
module pc_gen #(
    parameter int          ADDR_W     = 32,
    parameter logic [31:0] RESET_PC   = 32'hbfb00000,
    parameter int          STEP       = 4,
    parameter int          STALL_W    = 6,
    parameter int          STALL_BIT  = 0,
    parameter int          ALIGN_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STALL_W-1:0] stall,
    input  logic              imem_ready,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              pc_misaligned,
    output logic              br_pending
);

    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] STEP_ADDR  = ADDR_W'(STEP);
    // Mask of the low bits that must be zero; ALIGN_BITS=0 gives an all-zero
    // mask, which disables the check without needing a zero-width slice.
    localparam logic [ADDR_W-1:0] ALIGN_MASK =
        (ADDR_W'(1) << ALIGN_BITS) - ADDR_W'(1);

    logic [ADDR_W-1:0] pend_pc;

    logic              hold;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] pend_nxt;
    logic              brp_nxt;

    // Only one stall bit belongs to this stage; the rest are deliberately
    // ignored and folded here so they are visibly consumed.
    logic unused_stall;
    assign unused_stall = ^stall;

    assign hold = stall[STALL_BIT] | ~imem_ready;

    // Next-state selection. Before the first fetch (ce=0) only flush moves
    // the pc; a branch seen on that edge is parked as pending.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        pc_nxt   = pc;
        pend_nxt = pend_pc;
        brp_nxt  = br_pending;

        if (!ce) begin
            if (flush) begin
                pc_nxt  = flush_pc;
                brp_nxt = 1'b0;
            end else if (br_valid) begin
                pend_nxt = br_target;
                brp_nxt  = 1'b1;
            end
        end else if (flush) begin
            // Flush wins over everything and discards any parked branch.
            pc_nxt  = flush_pc;
            brp_nxt = 1'b0;
        end else if (hold) begin
            // Stage frozen: keep fetching the same address, but remember the
            // newest branch so it is not lost.
            if (br_valid) begin
                pend_nxt = br_target;
                brp_nxt  = 1'b1;
            end
        end else if (br_valid) begin
            // A live branch is younger than a parked one, so it wins.
            pc_nxt  = br_target;
            brp_nxt = 1'b0;
        end else if (br_pending) begin
            pc_nxt  = pend_pc;
            brp_nxt = 1'b0;
        end else begin
            pc_nxt = pc + STEP_ADDR;  // wraps modulo 2^ADDR_W
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: reset here is synchronous and covers every register,
            // including the parked branch target, so a mid-run reset is
            // indistinguishable from power-on.
            ce            <= 1'b0;
            pc            <= RESET_ADDR;
            pend_pc       <= '0;
            br_pending    <= 1'b0;
            pc_misaligned <= |(RESET_ADDR & ALIGN_MASK);
        end else begin
            ce            <= 1'b1;
            pc            <= pc_nxt;
            pend_pc       <= pend_nxt;
            br_pending    <= brp_nxt;
            // Derived from the new pc so the flag never lags the address.
            pc_misaligned <= |(pc_nxt & ALIGN_MASK);
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- self-checking bench for pc_gen (default parameters).
//
// Each cycle the bench drives inputs on the falling edge, advances a small
// reference model of the fetch unit and pushes the expected outputs into a
// scoreboard queue; one time unit after the next rising edge the entry is
// popped and compared with the DUT. Key addresses from the test plan are
// also checked against literal values.
// ---------------------------------------------------------------------------
module tb_pc_gen;

    localparam logic [31:0] RST_PC = 32'hbfb00000;

    typedef struct packed {
        logic [31:0] pc;
        logic        ce;
        logic        mis;
        logic        brp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        imem_ready;
    logic        br_valid;
    logic [31:0] br_target;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] pc;
    logic        ce;
    logic        pc_misaligned;
    logic        br_pending;

    pc_gen dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .imem_ready   (imem_ready),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .pc           (pc),
        .ce           (ce),
        .pc_misaligned(pc_misaligned),
        .br_pending   (br_pending)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    exp_t sb[$];

    // Reference model state
    logic [31:0] m_pc;
    logic        m_ce;
    logic        m_brp;
    logic [31:0] m_pend;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic step(input logic r, input logic [5:0] st, input logic rdy,
                        input logic bv, input logic [31:0] bt,
                        input logic fl, input logic [31:0] fp);
        exp_t e;
        exp_t got;
        logic h;
        @(negedge clk);
        rst = r; stall = st; imem_ready = rdy;
        br_valid = bv; br_target = bt; flush = fl; flush_pc = fp;

        h = st[0] | ~rdy;
        if (r) begin
            m_ce = 1'b0; m_pc = RST_PC; m_brp = 1'b0; m_pend = 32'h0;
        end else if (!m_ce) begin
            m_ce = 1'b1;
            if (fl) begin
                m_pc = fp; m_brp = 1'b0;
            end else if (bv) begin
                m_pend = bt; m_brp = 1'b1;
            end
        end else if (fl) begin
            m_pc = fp; m_brp = 1'b0;
        end else if (h) begin
            if (bv) begin
                m_pend = bt; m_brp = 1'b1;
            end
        end else if (bv) begin
            m_pc = bt; m_brp = 1'b0;
        end else if (m_brp) begin
            m_pc = m_pend; m_brp = 1'b0;
        end else begin
            m_pc = m_pc + 32'd4;
        end
        e.pc  = m_pc;
        e.ce  = m_ce;
        e.mis = (m_pc[1:0] != 2'b00);
        e.brp = m_brp;
        sb.push_back(e);

        @(posedge clk);
        #1;
        got = '{pc: pc, ce: ce, mis: pc_misaligned, brp: br_pending};
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("pc",         got.pc,          e.pc);
            check("ce",         32'(got.ce),     32'(e.ce));
            check("misaligned", 32'(got.mis),    32'(e.mis));
            check("br_pending", 32'(got.brp),    32'(e.brp));
        end
    endtask

    // Idle cycle shorthands
    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 6'd0, 1, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1, 6'd0, 1, 0, 32'h0, 0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; stall = '0; imem_ready = 1'b1; br_valid = 1'b0;
        br_target = '0; flush = 1'b0; flush_pc = '0;
        m_pc = RST_PC; m_ce = 1'b0; m_brp = 1'b0; m_pend = '0;

        // Reset and start-up sequence
        do_reset(3);
        check("rst_ce", 32'(ce), 32'd0);
        check("rst_pc", pc, 32'hbfb00000);
        run(1);
        check("first_ce", 32'(ce), 32'd1);
        check("first_pc", pc, 32'hbfb00000);
        run(1);
        check("seq_pc1", pc, 32'hbfb00004);
        run(1);
        check("seq_pc2", pc, 32'hbfb00008);
        run(2);
        check("seq_pc4", pc, 32'hbfb00010);

        // Stall bit 0 freezes; stall bit 5 is ignored
        step(0, 6'b000001, 1, 0, 32'h0, 0, 32'h0);
        step(0, 6'b000001, 1, 0, 32'h0, 0, 32'h0);
        check("stall_hold", pc, 32'hbfb00010);
        step(0, 6'b100000, 1, 0, 32'h0, 0, 32'h0);
        check("stall5_ignored", pc, 32'hbfb00014);

        // imem wait with branch captured on the second waiting cycle
        step(0, 6'd0, 0, 0, 32'h0,        0, 32'h0);
        step(0, 6'd0, 0, 1, 32'h80000100, 0, 32'h0);
        step(0, 6'd0, 0, 0, 32'h0,        0, 32'h0);
        check("wait_hold_pc", pc, 32'hbfb00014);
        check("wait_pending", 32'(br_pending), 32'd1);
        step(0, 6'd0, 1, 0, 32'h0, 0, 32'h0);
        check("wait_release_pc", pc, 32'h80000100);
        check("wait_release_brp", 32'(br_pending), 32'd0);

        // Newer held branch overwrites older one
        step(0, 6'b000001, 1, 1, 32'h00000a00, 0, 32'h0);
        step(0, 6'b000001, 1, 1, 32'h00000b00, 0, 32'h0);
        run(1);
        check("newest_pending", pc, 32'h00000b00);

        // Live branch beats stale pending branch
        step(0, 6'b000001, 1, 1, 32'h00000c00, 0, 32'h0);
        step(0, 6'd0, 1, 1, 32'h00000d00, 0, 32'h0);
        check("live_beats_pending", pc, 32'h00000d00);
        run(1);
        check("stale_dropped", pc, 32'h00000d04);

        // Flush discards a held pending branch
        step(0, 6'b000001, 1, 1, 32'h80000100, 0, 32'h0);
        step(0, 6'b000001, 1, 0, 32'h0, 1, 32'hbfc00380);
        check("flush_pc", pc, 32'hbfc00380);
        check("flush_clears_brp", 32'(br_pending), 32'd0);
        step(0, 6'b000001, 1, 0, 32'h0, 0, 32'h0);
        run(1);
        check("flush_no_stale", pc, 32'hbfc00384);

        // Branch and flush on the same edge
        step(0, 6'd0, 1, 1, 32'h00001000, 1, 32'h00002000);
        check("flush_over_br", pc, 32'h00002000);

        // Wrap-around
        step(0, 6'd0, 1, 0, 32'h0, 1, 32'hfffffffc);
        run(1);
        check("wrap", pc, 32'h00000000);

        // Misalignment flag tracks pc with no extra latency
        step(0, 6'd0, 1, 1, 32'h00000102, 0, 32'h0);
        check("mis_pc", pc, 32'h00000102);
        check("mis_set", 32'(pc_misaligned), 32'd1);
        run(1);
        step(0, 6'd0, 1, 0, 32'h0, 1, 32'h00000200);
        check("mis_clear", 32'(pc_misaligned), 32'd0);

        // Mid-run reset discards pending branch; first edge parks a branch;
        // flush on the first edge is honoured
        step(0, 6'b000001, 1, 1, 32'h00004000, 0, 32'h0);
        do_reset(2);
        check("midrst_brp", 32'(br_pending), 32'd0);
        step(0, 6'd0, 1, 1, 32'h00005000, 0, 32'h0);
        check("first_edge_parks_pc", pc, 32'hbfb00000);
        run(1);
        check("parked_applied", pc, 32'h00005000);
        do_reset(1);
        step(0, 6'd0, 1, 0, 32'h0, 1, 32'h00006000);
        check("ce0_flush", pc, 32'h00006000);
        run(2);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
